pe_bist_scan_ctrl: RTL and testbench
====================================

# pe_bist_scan_ctrl

Sequencer for the redundant-MAC built-in self-test of the `ROWS`×`COLS` systolic array. On a start pulse it walks every PE in row-major order and steers the redundant MAC's input muxes to that PE through `pe_row`/`pe_col`/`test_en`. After a fixed settle window it compares the PE's output against the redundant MAC's output. Mismatches are recorded in a per-PE fault map and a fault count, which the repair logic reads.

## Interface
- `ROWS`, 4, array rows
- `COLS`, 4, array columns
- `WORD_SIZE`, 16, datapath word width
- `SETTLE_CYCLES`, 4, cycles to wait after selecting a PE before comparing; must be ≥1
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle scan request; honoured only in IDLE
- `abort` in 1: synchronous scan cancel
- `stop_on_fail` in 1: when high, the first mismatch ends the scan; sampled with `start`
- `pe_out` in `WORD_SIZE`: output of the PE under test, routed by the array mux
- `rmac_out` in `WORD_SIZE`: redundant MAC bottom output
- `pe_row` out `max(1,$clog2(ROWS))`: row index of the PE under test
- `pe_col` out `max(1,$clog2(COLS))`: column index of the PE under test
- `test_en` out 1: redundant-MAC mux enable
- `busy` out 1: scan in progress
- `done` out 1: one-cycle pulse when a scan completes; no pulse on abort
- `fault_map` out `ROWS*COLS`: bit `r*COLS+c` is set when PE(r,c) failed
- `fault_count` out `$clog2(ROWS*COLS+1)`: number of set bits in `fault_map`

## Operation
- States: IDLE, SELECT, SETTLE, COMPARE, DONE.
- **IDLE**: on `start`=1:
  - clear `fault_map` and `fault_count`;
  - set `pe_row` = `pe_col` = 0;
  - latch `stop_on_fail`;
  - go to SELECT.
- **SELECT** (1 cycle): `test_en`=1; load settle counter with `SETTLE_CYCLES`-1; go to SETTLE.
- **SETTLE**: `test_en`=1; decrement the counter each cycle; at 0, go to COMPARE.
- **COMPARE** (1 cycle): `test_en`=1; compare `pe_out` with `rmac_out` on all `WORD_SIZE` bits.
  - On mismatch: set `fault_map` bit and increment `fault_count`.
  - If the PE was the last one (`pe_row`=`ROWS`-1, `pe_col`=`COLS`-1), or a mismatch occurred with latched `stop_on_fail`=1, go to DONE.
  - Otherwise advance the index and go to SELECT. `pe_col` increments; on wrap to 0, `pe_row` increments.
- **DONE** (1 cycle): `done`=1, `busy`=0, `test_en`=0; go to IDLE.
- `busy`=1 in SELECT, SETTLE and COMPARE only.
- `test_en`=0 in IDLE and DONE.
- On stop-on-fail, `pe_row`/`pe_col` hold the failing PE's index until the next `start`.
- `abort`=1 in SELECT, SETTLE or COMPARE:
  - go to IDLE on the next edge and do not pulse `done`;
  - abort takes priority over a same-cycle compare result, so no fault bit is recorded for that cycle;
  - `fault_map` and `fault_count` keep the results gathered so far.
- `abort` in IDLE or DONE has no effect.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: the scan starts.
- `fault_map`, `fault_count`, `pe_row` and `pe_col` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE. All outputs are 0: `busy`, `done`, `test_en`, `pe_row`, `pe_col`, `fault_map`, `fault_count`.
- Reset asserted mid-scan discards the scan immediately.
- Per-PE cost: `SETTLE_CYCLES`+2 cycles.
- `start` sampled at edge T:
  - `busy` and `test_en` go high after T;
  - SELECT for PE(0,0) occupies cycle T+1;
  - COMPARE for PE k occupies cycle T+(k+1)(`SETTLE_CYCLES`+2).
- Full scan: `done` is high in cycle T+`ROWS`·`COLS`·(`SETTLE_CYCLES`+2)+1. With defaults that is T+97.
- `fault_map` and `fault_count` update at the edge ending COMPARE and are visible in the following cycle.
- `pe_row`/`pe_col` change only at the edge leaving COMPARE, so the mux select is stable for the whole SELECT+SETTLE+COMPARE window.

## Test plan
- Defaults, `pe_out`=`rmac_out` always, `start` at T:
  - `done` pulses exactly at T+97;
  - `busy` is high T+1..T+96;
  - `fault_map`=16'h0000, `fault_count`=0;
  - `pe_row`/`pe_col` step (0,0),(0,1)…(3,3) every 6 cycles.
- Mismatch forced only while `pe_row`=1,`pe_col`=2 and while `pe_row`=3,`pe_col`=0, `stop_on_fail`=0:
  - `fault_map`=16'h1040, `fault_count`=2;
  - `done` still at T+97.
- Same fault on PE(1,2) with `stop_on_fail`=1:
  - `done` at T+6·7+1=T+43;
  - `fault_map`=16'h0040, `fault_count`=1;
  - `pe_row`=1, `pe_col`=2 are held in IDLE.
- `abort` in cycle T+20, with a fault on PE(0,1):
  - IDLE at T+21 and `done` never pulses;
  - `fault_map`=16'h0002 retained;
  - a fresh `start` clears it to 0.
- `start` pulsed repeatedly while busy: no effect, and scan timing is identical to the first scenario.
- `rst` driven low asynchronously mid-SETTLE: all outputs 0 immediately, without waiting for a clock edge; a following `start` performs a full scan from PE(0,0).

Source files
------------

// File: rtl/pe_bist_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_bist_scan_ctrl
// Purpose  : Walks every PE of the systolic array against the redundant MAC.
//            It records each mismatching PE in a fault map and a fault count.
// Revision : 1.0 - initial release
// ============================================================================
module pe_bist_scan_ctrl #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int WORD_SIZE     = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 stop_on_fail,
  input  logic [WORD_SIZE-1:0]                 pe_out,
  input  logic [WORD_SIZE-1:0]                 rmac_out,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] pe_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] pe_col,
  output logic                                 test_en,
  output logic                                 busy,
  output logic                                 done,
  output logic [ROWS*COLS-1:0]                 fault_map,
  output logic [$clog2(ROWS*COLS+1)-1:0]       fault_count
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NPE   = ROWS * COLS;
  localparam int IDX_W = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int FCW   = $clog2(NPE + 1);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [ROW_W-1:0] c_last_row   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] c_last_col   = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] c_settle_ld  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic               r_stop_on_fail;
  logic [ROW_W-1:0]   r_pe_row;
  logic [COL_W-1:0]   r_pe_col;
  logic               r_test_en;
  logic               r_busy;
  logic               r_done;
  logic [NPE-1:0]     r_fault_map;
  logic [FCW-1:0]     r_fault_count;

  logic               w_mismatch;
  logic               w_last_pe;
  logic [IDX_W-1:0]   w_pe_idx;
  logic [NPE-1:0]     w_pe_bit;

  assign w_mismatch = (pe_out != rmac_out);
  assign w_last_pe  = (r_pe_row == c_last_row) && (r_pe_col == c_last_col);
  assign w_pe_idx   = IDX_W'(r_pe_row) * IDX_W'(COLS) + IDX_W'(r_pe_col);
  assign w_pe_bit   = NPE'(1) << w_pe_idx;

  // Index, map and count are held across abort and DONE; only start clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_settle_cnt   <= '0;
      r_stop_on_fail <= 1'b0;
      r_pe_row       <= '0;
      r_pe_col       <= '0;
      r_test_en      <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fault_map    <= '0;
      r_fault_count  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fault_map    <= '0;
            r_fault_count  <= '0;
            r_pe_row       <= '0;
            r_pe_col       <= '0;
            r_stop_on_fail <= stop_on_fail;
            r_busy         <= 1'b1;
            r_test_en      <= 1'b1;
            r_state        <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (abort) begin
            r_busy    <= 1'b0;
            r_test_en <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_settle_cnt <= c_settle_ld;
            r_state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            r_busy    <= 1'b0;
            r_test_en <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_settle_cnt == '0) begin
            r_state <= S_COMPARE;
          end else begin
            r_settle_cnt <= r_settle_cnt - CNT_W'(1);
          end
        end

        S_COMPARE: begin
          if (abort) begin
            r_busy    <= 1'b0;
            r_test_en <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            if (w_mismatch) begin
              r_fault_map   <= r_fault_map | w_pe_bit;
              r_fault_count <= r_fault_count + FCW'(1);
            end
            if (w_last_pe || (w_mismatch && r_stop_on_fail)) begin
              r_busy    <= 1'b0;
              r_test_en <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              if (r_pe_col == c_last_col) begin
                r_pe_col <= '0;
                r_pe_row <= r_pe_row + ROW_W'(1);
              end else begin
                r_pe_col <= r_pe_col + COL_W'(1);
              end
              r_state <= S_SELECT;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_busy    <= 1'b0;
          r_test_en <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign pe_row      = r_pe_row;
  assign pe_col      = r_pe_col;
  assign test_en     = r_test_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fault_map   = r_fault_map;
  assign fault_count = r_fault_count;

endmodule
`default_nettype wire

// File: tb/tb_pe_bist_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_bist_scan_ctrl
// Purpose  : Self-checking bench for pe_bist_scan_ctrl against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_bist_scan_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int WS   = 16;
  localparam int SC   = 4;
  localparam int NPE  = ROWS * COLS;
  localparam int PER  = SC + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stop_on_fail = 1'b0;
  logic [WS-1:0] pe_out;
  logic [WS-1:0] rmac_out = '0;
  logic [WS-1:0] r_flip = 16'h0001;
  logic [1:0]    pe_row;
  logic [1:0]    pe_col;
  logic          test_en;
  logic          busy;
  logic          done;
  logic [NPE-1:0] fault_map;
  logic [4:0]    fault_count;
  logic [NPE-1:0] cur_faults = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        busy;
    logic        te;
    logic        done;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [15:0] map;
    logic [4:0]  cnt;
  } obs_t;

  typedef struct {
    logic [15:0] f;
    bit          sof;
    int          a;
    bit          spam;
    int          exp_done;
    logic [15:0] exp_map;
    int          exp_cnt;
    int          exp_row;
    int          exp_col;
  } vec_t;

  always #5 clk = ~clk;

  pe_bist_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stop_on_fail(stop_on_fail), .pe_out(pe_out), .rmac_out(rmac_out),
    .pe_row(pe_row), .pe_col(pe_col), .test_en(test_en), .busy(busy),
    .done(done), .fault_map(fault_map), .fault_count(fault_count)
  );

  // A faulty PE differs from the redundant MAC by a random (often single-bit) flip.
  always @(posedge clk) begin
    rmac_out <= WS'($urandom);
    r_flip   <= ($urandom_range(1, 0) == 1) ? (16'h0001 << $urandom_range(15, 0))
                                            : (WS'($urandom) | 16'h0001);
  end
  assign pe_out = cur_faults[{pe_row, pe_col}] ? (rmac_out ^ r_flip) : rmac_out;

  function automatic int last_pe(input logic [15:0] f, input bit sof);
    int k_end = NPE - 1;
    if (sof)
      for (int k = NPE - 1; k >= 0; k--)
        if (f[k]) k_end = k;
    return k_end;
  endfunction

  // Cycle n counts from 1 = the cycle right after the edge that sampled start.
  function automatic int done_cycle(input logic [15:0] f, input bit sof, input int a);
    int dc = (last_pe(f, sof) + 1) * PER + 1;
    if (a > 0 && a < dc) return -1;
    return dc;
  endfunction

  function automatic obs_t model(input int n, input logic [15:0] f, input bit sof, input int a);
    obs_t o;
    int k_end = last_pe(f, sof);
    int dc = (k_end + 1) * PER + 1;
    int idx;
    int upto;
    logic [15:0] m = '0;
    o = '0;
    if (a > 0 && a < dc && n > a) begin
      idx  = (a - 1) / PER;
      upto = a;
    end else if (n < dc) begin
      o.busy = 1'b1;
      o.te   = 1'b1;
      idx    = (n - 1) / PER;
      upto   = n;
    end else begin
      o.done = (n == dc);
      idx    = k_end;
      upto   = dc;
    end
    for (int k = 0; k < NPE; k++)
      if (f[k] && (k + 1) * PER < upto) m[k] = 1'b1;
    o.row = 2'(idx / COLS);
    o.col = 2'(idx % COLS);
    o.map = m;
    o.cnt = 5'($countones(m));
    return o;
  endfunction

  task automatic check_zero(input string tag);
    obs_t got;
    got = {busy, test_en, done, pe_row, pe_col, fault_map, fault_count};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s: outputs got %h, required 0", tag, got);
    end
  endtask

  task automatic run_scan(input logic [15:0] f, input bit sof, input int a,
                          input bit spam, input int rst_at, output int done_at);
    obs_t e;
    obs_t got;
    int   stop_n;
    int   dc = done_cycle(f, sof, a);
    stop_n  = (dc < 0) ? a : dc;
    done_at = -1;
    cur_faults = f;
    @(negedge clk);
    start        = 1'b1;
    stop_on_fail = sof;
    abort        = 1'($urandom_range(1, 0));
    @(negedge clk);
    start        = 1'b0;
    abort        = 1'b0;
    stop_on_fail = 1'($urandom_range(1, 0));
    for (int n = 1; n <= 130; n++) begin
      if (n == rst_at) begin
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      e   = model(n, f, sof, a);
      got = {busy, test_en, done, pe_row, pe_col, fault_map, fault_count};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle %0d: got b/te/d/r/c/map/cnt %b%b%b %0d %0d %h %0d, required %b%b%b %0d %0d %h %0d",
                 n, got.busy, got.te, got.done, got.row, got.col, got.map, got.cnt,
                 e.busy, e.te, e.done, e.row, e.col, e.map, e.cnt);
      end
      if (done === 1'b1 && done_at < 0) done_at = n;
      abort = (n == a) || (!e.busy && $urandom_range(1, 0) == 1);
      start = spam && e.busy && ($urandom_range(1, 0) == 1);
      if (n >= stop_n + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic cmp(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", tag, got, exp);
    end
  endtask

  initial begin
    vec_t        vecs[5];
    int          done_at;
    logic [15:0] f;
    bit          sof;
    int          a;

    vecs[0] = '{16'h0000, 1'b0, 0,  1'b0, 97, 16'h0000, 0, 3, 3};
    vecs[1] = '{16'h1040, 1'b0, 0,  1'b0, 97, 16'h1040, 2, 3, 3};
    vecs[2] = '{16'h0040, 1'b1, 0,  1'b0, 43, 16'h0040, 1, 1, 2};
    vecs[3] = '{16'h0002, 1'b0, 20, 1'b0, -1, 16'h0002, 1, 0, 3};
    vecs[4] = '{16'h0000, 1'b0, 0,  1'b1, 97, 16'h0000, 0, 3, 3};

    #12 check_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].f, vecs[i].sof, vecs[i].a, vecs[i].spam, 0, done_at);
      cmp($sformatf("vec%0d done_cycle", i), done_at, vecs[i].exp_done);
      cmp($sformatf("vec%0d fault_map", i), int'(fault_map), int'(vecs[i].exp_map));
      cmp($sformatf("vec%0d fault_count", i), int'(fault_count), vecs[i].exp_cnt);
      cmp($sformatf("vec%0d pe_row", i), int'(pe_row), vecs[i].exp_row);
      cmp($sformatf("vec%0d pe_col", i), int'(pe_col), vecs[i].exp_col);
    end

    for (int i = 0; i < 8; i++) begin
      f   = 16'($urandom) & 16'($urandom) & 16'($urandom);
      sof = 1'($urandom_range(1, 0));
      a   = ($urandom_range(2, 0) == 0) ? $urandom_range(90, 1) : 0;
      run_scan(f, sof, a, 1'($urandom_range(1, 0)), 0, done_at);
      cmp($sformatf("rand%0d done_cycle", i), done_at, done_cycle(f, sof, a));
    end

    // Reset lands mid-SETTLE of PE(0,1) after PE(0,0) has already failed.
    run_scan(16'h0001, 1'b0, 0, 1'b0, 9, done_at);
    run_scan(16'h0000, 1'b0, 0, 1'b0, 0, done_at);
    cmp("post_reset done_cycle", done_at, 97);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
